arbiter_rr_4: RTL
=================

// Module: arbiter_rr_4
// PURPOSE
// Round-robin arbiter that shares one resource between four requesters and
// drives a one-hot grant through a 2-to-4 decoder. It sits between the
// requesting cell/row engines and the shared resource. Each grant is held
// while the owner keeps requesting, up to MAX_HOLD cycles, then is
// preempted if another requester is waiting.
// PARAMETERS
// MAX_HOLD  8                  max consecutive grant cycles while others wait (>=1)
// HOLD_W    $clog2(MAX_HOLD+1) hold-counter width; derived, do not override
// PORTS
// clk        in   1  system clock, rising edge
// rst        in   1  asynchronous, active-high reset
// ena        in   1  arbiter enable; low forces gnt to 0
// req        in   4  request per requester, level-sensitive
// gnt        out  4  one-hot grant, all zero when no owner
// gnt_idx    out  2  index of current owner; valid only when gnt_valid=1
// gnt_valid  out  1  a grant is active this cycle
// preempt    out  1  one-cycle pulse: grant was taken by hold expiry
// BEHAVIOUR
// - Reset (async, any time): state=IDLE, ptr=0, hold_cnt=0, gnt=0,
//   gnt_idx=0, gnt_valid=0, preempt=0. A reset mid-grant drops gnt at once.
// - All state is registered. gnt = decoder(gnt_idx) gated by gnt_valid & ena.
// - Selection: scan req from ptr upward, mod 4; the first set bit wins.
//   ptr becomes winner+1 (mod 4, 2-bit wrap 3->0) on every new grant.
// - FSM IDLE: if ena & |req, go to GRANT with winner; hold_cnt=1.
//   Latency is req-high edge -> gnt high at the next edge (1 cycle).
// - FSM GRANT, owner req still high:
//   * no other req, or hold_cnt<MAX_HOLD: keep owner; hold_cnt++ saturating
//     at MAX_HOLD.
//   * hold_cnt==MAX_HOLD and another req pending: select among the others
//     (owner excluded) from ptr; new grant at next edge, hold_cnt=1,
//     preempt=1 for that one cycle.
// - FSM GRANT, owner req low: no bubble. If another req is high, it is
//   granted at the next edge (hold_cnt=1, preempt=0). Otherwise go to IDLE,
//   gnt=0.
// - Simultaneous owner drop and hold expiry count as a release: preempt=0.
// - ena low: gnt=0 combinationally, gnt_valid=0. Next edge goes to IDLE and
//   hold_cnt=0. ptr is kept, so fairness survives disable.
// - MAX_HOLD=1: every cycle with contention rotates ownership.
// - req is never masked by gnt. A requester stays granted only while it
//   holds req high.
// - gnt is never multi-hot. gnt is zero exactly when gnt_valid=0.
// STRUCTURE
// - Shared package arbiter_pkg: typedef enum logic {S_IDLE, S_GRANT}
//   arb_state_t; localparam N_REQ=4; typedef logic [1:0] req_idx_t.
// - Sub-module: the existing decoder_2_to_4 instance, with ena=gnt_valid&ena,
//   in=gnt_idx, out=gnt.
// - Rotating priority pick as a combinational function in the package:
//   pick(req, ptr, excl_mask) -> {found, idx}.
// TESTING
// - rst pulsed mid-grant, asynchronous to clk -> gnt=0, gnt_valid=0 before
//   the next edge. After release, req=4'b0001 -> gnt=4'b0001 one edge later.
// - req=4'b1111 held, MAX_HOLD=8 -> owners 0,1,2,3,0 in turn, each for
//   exactly 8 cycles; preempt pulses at each handover.
// - req=4'b0100 alone for 20 cycles -> gnt=4'b0100 all 20 cycles,
//   preempt stays 0.
// - Owner 1 drops req while req[3] is high -> gnt goes 4'b0010 to 4'b1000
//   on the next edge, no zero cycle between.
// - ena low for 3 cycles during grant to 2 (ptr=3), then req=4'b0101 ->
//   gnt=0 while disabled, then gnt=4'b0001 (ptr wrap 3->0).
// - Random req for 10k cycles -> assert gnt one-hot or zero, no requester
//   waits more than 3*MAX_HOLD+3 cycles.

Source files
------------

// File: rtl/arbiter_pkg.sv
// Shared types and rotating-priority pick for the 4-way round-robin arbiter.
// Pure combinational helpers; no state, no backpressure.
package arbiter_pkg;

    typedef enum logic {S_IDLE, S_GRANT} arb_state_t;

    localparam int N_REQ = 4;

    typedef logic [1:0] req_idx_t;

    // Returns {found, idx}: first set bit of req & ~excl_mask scanning upward from ptr, mod 4.
    function automatic logic [2:0] pick(input logic [N_REQ-1:0] req,
                                        input req_idx_t         ptr,
                                        input logic [N_REQ-1:0] excl_mask);
        logic [N_REQ-1:0] cand;
        req_idx_t         idx;
        logic [2:0]       res;
        cand = req & ~excl_mask;
        res  = 3'b000;
        // Walk from the farthest offset down so the nearest candidate is written last.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr + req_idx_t'(k);
            if (cand[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/arbiter_rr_4_decoder.sv
// 2-to-4 one-hot decoder with enable; zero latency, all-zero output when disabled.
// Combinational only, no backpressure.
module decoder_2_to_4 (
    input  logic       ena,
    input  logic [1:0] in,
    output logic [3:0] out
);

    always_comb begin
        out = 4'b0000;
        if (ena) begin
            out[in] = 1'b1;
        end
    end

endmodule

// File: rtl/arbiter_rr_4.sv
// Round-robin 4-way arbiter with bounded grant hold and preemption on expiry.
// Latency: request edge -> grant one edge later; ena low blanks the grant combinationally.
module arbiter_rr_4
    import arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output req_idx_t         gnt_idx,
    output logic             gnt_valid,
    output logic             preempt
);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    arb_state_t        state, state_nxt;
    req_idx_t          ptr, ptr_nxt;
    req_idx_t          idx_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              pre_nxt;
    logic [N_REQ-1:0]  owner_mask;
    logic              others_pending;
    logic [2:0]        sel;
    logic              take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt_idx  <= '0;
            preempt  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            gnt_idx  <= idx_nxt;
            preempt  <= pre_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        ptr_nxt        = ptr;
        hold_nxt       = hold_cnt;
        idx_nxt        = gnt_idx;
        pre_nxt        = 1'b0;
        take           = 1'b0;
        sel            = 3'b000;
        owner_mask     = 4'b0001 << gnt_idx;
        others_pending = |(req & ~owner_mask);

        if (!ena) begin
            // ptr deliberately untouched so rotation resumes where it left off.
            state_nxt = S_IDLE;
            hold_nxt  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    sel  = pick(req, ptr, '0);
                    take = sel[2];
                end
                S_GRANT: begin
                    if (req[gnt_idx]) begin
                        if (hold_cnt == HOLD_MAX && others_pending) begin
                            sel     = pick(req, ptr, owner_mask);
                            take    = 1'b1;
                            pre_nxt = 1'b1;
                        end else if (hold_cnt != HOLD_MAX) begin
                            hold_nxt = hold_cnt + HOLD_W'(1);
                        end
                    end else if (others_pending) begin
                        // Owner released with someone waiting: hand over without a bubble.
                        sel  = pick(req, ptr, owner_mask);
                        take = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                        hold_nxt  = '0;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase

            if (take) begin
                state_nxt = S_GRANT;
                idx_nxt   = sel[1:0];
                ptr_nxt   = sel[1:0] + req_idx_t'(1);
                hold_nxt  = HOLD_W'(1);
            end
        end
    end

    assign gnt_valid = (state == S_GRANT) & ena;

    decoder_2_to_4 u_dec (
        .ena (gnt_valid & ena),
        .in  (gnt_idx),
        .out (gnt)
    );

endmodule
